// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types, constants and counter helper for the PHT scheduler
package bp_pkg;

  typedef enum logic [1:0] {INIT, IDLE, UPD_RD, UPD_WR} bp_state_t;

  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_MAX = 2'b11;

  // Queue entries carry a fixed-width index; the top uses only its low IDX_W bits.
  localparam int IDX_MAX_W = 16;

  typedef struct packed {
    logic [IDX_MAX_W-1:0] idx;
    logic                 taken;
  } upd_entry_t;

  function automatic logic [1:0] ctr_update(input logic [1:0] c, input logic taken);
    if (taken) return (c == CTR_MAX) ? CTR_MAX : c + 2'd1;
    else       return (c == 2'b00)   ? 2'b00   : c - 2'd1;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// rtl/bp_upd_fifo.sv - synchronous FIFO holding resolved branch updates
module bp_upd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bp_pht_scheduler.sv
// rtl/bp_pht_scheduler.sv - single-port PHT arbiter, BHR owner and counter RMW sequencer
// Optional macro BP_UPD_BYPASS_EN lets an update skip an empty queue when fetch is idle.
module bp_pht_scheduler
  import bp_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_DEFER   = 8,
  parameter int BHR_BITS    = 4,
  parameter int BHR_ENTRIES = 8,
  parameter int PC_IDX_BITS = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            lookup_valid,
  input  logic [31:0]                     lookup_pc,
  output logic                            lookup_ready,
  output logic                            pred_valid,
  output logic                            pred_taken,
  input  logic                            upd_valid,
  input  logic [31:0]                     upd_pc,
  input  logic                            upd_taken,
  output logic                            upd_ready,
  output logic                            pht_en,
  output logic                            pht_we,
  output logic [PC_IDX_BITS+BHR_BITS-1:0] pht_addr,
  output logic [1:0]                      pht_wdata,
  input  logic [1:0]                      pht_rdata,
  output logic                            init_done
);

  localparam int IDX_W = PC_IDX_BITS + BHR_BITS;
  localparam int SEL_W = $clog2(BHR_ENTRIES);
  localparam int DEF_W = $clog2(MAX_DEFER + 1);
  localparam int EW    = $bits(upd_entry_t);

  bp_state_t         r_state;
  logic [IDX_W-1:0]  r_sweep;
  logic [BHR_BITS-1:0] r_bhr [BHR_ENTRIES];
  logic [DEF_W-1:0]  r_defer;
  logic [IDX_W-1:0]  r_lat_idx;
  logic              r_lat_taken;
  logic [1:0]        r_new_ctr;
  logic              r_init_done;
  logic              r_pred_valid;

  logic [SEL_W-1:0]  w_lk_sel;
  logic [SEL_W-1:0]  w_upd_sel;
  logic [IDX_W-1:0]  w_lk_idx;
  logic [IDX_W-1:0]  w_upd_idx;
  upd_entry_t        w_din_e;
  upd_entry_t        w_head_e;
  logic [EW-1:0]     w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_upd_hs;
  logic              w_upd_win;
  logic              w_bypass;
  logic              w_push;
  logic              w_in_idle;
  logic              w_unused;

  assign w_lk_sel  = lookup_pc[SEL_W+2:3];
  assign w_upd_sel = upd_pc[SEL_W+2:3];
  assign w_lk_idx  = {lookup_pc[PC_IDX_BITS+3:4], r_bhr[w_lk_sel]};
  assign w_upd_idx = {upd_pc[PC_IDX_BITS+3:4], r_bhr[w_upd_sel]};

  assign w_din_e.idx   = IDX_MAX_W'(w_upd_idx);
  assign w_din_e.taken = upd_taken;
  assign w_head_e      = upd_entry_t'(w_head);
  assign w_unused      = ^{lookup_pc, upd_pc, w_head_e.idx};

  assign w_in_idle = (r_state == IDLE);
  assign upd_ready = r_init_done && !w_full;
  assign w_upd_hs  = upd_valid && upd_ready;
  assign w_upd_win = w_in_idle && !w_empty &&
                     (!lookup_valid || (r_defer == DEF_W'(MAX_DEFER)) || w_full);
`ifdef BP_UPD_BYPASS_EN
  assign w_bypass  = w_in_idle && w_empty && !lookup_valid && w_upd_hs;
`else
  assign w_bypass  = 1'b0;
`endif
  assign w_push       = w_upd_hs && !w_bypass;
  assign lookup_ready = w_in_idle && !w_upd_win && !w_bypass && lookup_valid;
  assign pred_valid   = r_pred_valid;
  assign pred_taken   = r_pred_valid & pht_rdata[1];
  assign init_done    = r_init_done;

  bp_upd_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_din_e),
    .i_pop   (w_upd_win),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // The sweep strobe is gated by rst_n so the RAM sees no access while reset is held.
  always_comb begin
    pht_en    = 1'b0;
    pht_we    = 1'b0;
    pht_addr  = '0;
    pht_wdata = '0;
    case (r_state)
      INIT: if (rst_n) begin
        pht_en = 1'b1; pht_we = 1'b1; pht_addr = r_sweep; pht_wdata = CTR_WNT;
      end
      IDLE: begin
        if (w_upd_win) begin
          pht_en = 1'b1; pht_addr = w_head_e.idx[IDX_W-1:0];
        end else if (w_bypass) begin
          pht_en = 1'b1; pht_addr = w_upd_idx;
        end else if (lookup_ready) begin
          pht_en = 1'b1; pht_addr = w_lk_idx;
        end
      end
      UPD_WR: begin
        pht_en = 1'b1; pht_we = 1'b1; pht_addr = r_lat_idx; pht_wdata = r_new_ctr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= INIT;
      r_sweep      <= '0;
      r_defer      <= '0;
      r_lat_idx    <= '0;
      r_lat_taken  <= 1'b0;
      r_new_ctr    <= '0;
      r_init_done  <= 1'b0;
      r_pred_valid <= 1'b0;
      for (int i = 0; i < BHR_ENTRIES; i++) r_bhr[i] <= '0;
    end else begin
      r_pred_valid <= lookup_ready;
      if (w_upd_hs) r_bhr[w_upd_sel] <= {r_bhr[w_upd_sel][BHR_BITS-2:0], upd_taken};
      case (r_state)
        INIT: begin
          r_sweep <= r_sweep + 1'b1;
          if (&r_sweep) begin
            r_state     <= IDLE;
            r_init_done <= 1'b1;
          end
        end
        IDLE: begin
          if (w_upd_win) begin
            r_lat_idx   <= w_head_e.idx[IDX_W-1:0];
            r_lat_taken <= w_head_e.taken;
            r_defer     <= '0;
            r_state     <= UPD_RD;
          end else if (w_bypass) begin
            r_lat_idx   <= w_upd_idx;
            r_lat_taken <= upd_taken;
            r_state     <= UPD_RD;
          end else if (lookup_ready && !w_empty && (r_defer != DEF_W'(MAX_DEFER))) begin
            r_defer <= r_defer + 1'b1;
          end
        end
        UPD_RD: begin
          r_new_ctr <= ctr_update(pht_rdata, r_lat_taken);
          r_state   <= UPD_WR;
        end
        UPD_WR:  r_state <= IDLE;
        default: r_state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_pht_scheduler.sv
// tb/tb_bp_pht_scheduler.sv - directed self-checking bench with a behavioural PHT RAM
module tb_bp_pht_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        lookup_ready;
  logic        pred_valid;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_ready;
  logic        pht_en;
  logic        pht_we;
  logic [5:0]  pht_addr;
  logic [1:0]  pht_wdata;
  logic [1:0]  pht_rdata = 2'b00;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  logic [1:0] ram [64];

  bp_pht_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_valid (lookup_valid),
    .lookup_pc    (lookup_pc),
    .lookup_ready (lookup_ready),
    .pred_valid   (pred_valid),
    .pred_taken   (pred_taken),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_ready    (upd_ready),
    .pht_en       (pht_en),
    .pht_we       (pht_we),
    .pht_addr     (pht_addr),
    .pht_wdata    (pht_wdata),
    .pht_rdata    (pht_rdata),
    .init_done    (init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pht_en) begin
      if (pht_we) ram[pht_addr] <= pht_wdata;
      else        pht_rdata     <= ram[pht_addr];
    end
  end

  task automatic test_reset();
    int bad;
    for (int i = 0; i < 64; i++) ram[i] = 2'b11;
    rst_n = 1'b0; lookup_valid = 1'b1; lookup_pc = 32'h10;
    upd_valid = 1'b1; upd_pc = 32'h18; upd_taken = 1'b1;
    repeat (2) @(negedge clk);
    #1; checks++;
    if ({lookup_ready, pred_valid, pred_taken, upd_ready, pht_en, pht_we, pht_addr, pht_wdata, init_done} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b pv=%b pt=%b urdy=%b en=%b we=%b addr=%h wd=%b done=%b, expected all 0",
               lookup_ready, pred_valid, pred_taken, upd_ready, pht_en, pht_we, pht_addr, pht_wdata, init_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 64; k++) begin
      #1; checks++;
      if (!(pht_en === 1'b1 && pht_we === 1'b1 && pht_addr === 6'(k) && pht_wdata === 2'b01 &&
            init_done === 1'b0 && upd_ready === 1'b0 && lookup_ready === 1'b0)) begin
        errors++;
        $display("FAIL init_sweep[%0d]: en=%b we=%b addr=%0d wd=%b done=%b urdy=%b lrdy=%b, expected 1 1 %0d 01 0 0 0",
                 k, pht_en, pht_we, pht_addr, pht_wdata, init_done, upd_ready, lookup_ready, k);
      end
      if (k == 63) begin lookup_valid = 1'b0; upd_valid = 1'b0; end
      @(negedge clk);
    end
    #1; checks++;
    if (!(init_done === 1'b1 && upd_ready === 1'b1 && pht_en === 1'b0)) begin
      errors++;
      $display("FAIL init_done_rise: done=%b urdy=%b en=%b, expected 1 1 0", init_done, upd_ready, pht_en);
    end
    bad = 0;
    for (int i = 0; i < 64; i++) if (ram[i] !== 2'b01) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL init_contents: %0d entries not 01, expected 0", bad);
    end
  endtask

  task automatic test_lookup();
    @(negedge clk);
    lookup_valid = 1'b1; lookup_pc = 32'h10;
    #1; checks++;
    if (!(lookup_ready === 1'b1 && pht_en === 1'b1 && pht_we === 1'b0 && pht_addr === 6'b01_0000)) begin
      errors++;
      $display("FAIL lookup_issue: rdy=%b en=%b we=%b addr=%b, expected 1 1 0 010000", lookup_ready, pht_en, pht_we, pht_addr);
    end
    @(negedge clk);
    lookup_valid = 1'b0;
    #1; checks++;
    if (!(pred_valid === 1'b1 && pred_taken === 1'b0)) begin
      errors++;
      $display("FAIL lookup_pred: pv=%b pt=%b, expected 1 0", pred_valid, pred_taken);
    end
    @(negedge clk);
    #1; checks++;
    if (pred_valid !== 1'b0) begin
      errors++;
      $display("FAIL lookup_pred_drop: pv=%b, expected 0", pred_valid);
    end
  endtask

  task automatic test_update_saturate();
    logic [5:0] exp_addr [7] = '{6'b010000, 6'b010001, 6'b010011, 6'b010111, 6'b011111, 6'b011111, 6'b011111};
    logic [1:0] exp_wd   [7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      upd_valid = 1'b1; upd_pc = 32'h18; upd_taken = 1'b1;
      #1; checks++;
      if (!(upd_ready === 1'b1 && pht_en === 1'b0)) begin
        errors++;
        $display("FAIL upd%0d_push: urdy=%b en=%b, expected 1 0", i, upd_ready, pht_en);
      end
      @(negedge clk);
      upd_valid = 1'b0;
      #1; checks++;
      if (!(pht_en === 1'b1 && pht_we === 1'b0 && pht_addr === exp_addr[i])) begin
        errors++;
        $display("FAIL upd%0d_read: en=%b we=%b addr=%b, expected 1 0 %b", i, pht_en, pht_we, pht_addr, exp_addr[i]);
      end
      @(negedge clk);
      #1; checks++;
      if (pht_en !== 1'b0) begin
        errors++;
        $display("FAIL upd%0d_rd_gap: en=%b, expected 0", i, pht_en);
      end
      @(negedge clk);
      #1; checks++;
      if (!(pht_en === 1'b1 && pht_we === 1'b1 && pht_addr === exp_addr[i] && pht_wdata === exp_wd[i])) begin
        errors++;
        $display("FAIL upd%0d_write: en=%b we=%b addr=%b wd=%b, expected 1 1 %b %b",
                 i, pht_en, pht_we, pht_addr, pht_wdata, exp_addr[i], exp_wd[i]);
      end
      if (i == 2) begin
        @(negedge clk);
        lookup_valid = 1'b1; lookup_pc = 32'h18;
        #1; checks++;
        if (!(lookup_ready === 1'b1 && pht_addr === 6'b010111)) begin
          errors++;
          $display("FAIL bhr3_after3: rdy=%b addr=%b, expected 1 010111", lookup_ready, pht_addr);
        end
        lookup_valid = 1'b0;
      end
    end
    @(negedge clk);
    lookup_valid = 1'b1; lookup_pc = 32'h18;
    #1; checks++;
    if (!(lookup_ready === 1'b1 && pht_addr === 6'b011111)) begin
      errors++;
      $display("FAIL sat_lookup: rdy=%b addr=%b, expected 1 011111", lookup_ready, pht_addr);
    end
    @(negedge clk);
    lookup_valid = 1'b0;
    #1; checks++;
    if (!(pred_valid === 1'b1 && pred_taken === 1'b1)) begin
      errors++;
      $display("FAIL sat_pred: pv=%b pt=%b, expected 1 1", pred_valid, pred_taken);
    end
  endtask

  task automatic test_defer();
    int grants = 0;
    int pv_bad = 0;
    @(negedge clk);
    lookup_valid = 1'b1; lookup_pc = 32'h10;
    upd_valid = 1'b1; upd_pc = 32'h20; upd_taken = 1'b0;
    #1; checks++;
    if (!(lookup_ready === 1'b1 && upd_ready === 1'b1 && pht_addr === 6'b010000)) begin
      errors++;
      $display("FAIL defer_c0: lrdy=%b urdy=%b addr=%b, expected 1 1 010000", lookup_ready, upd_ready, pht_addr);
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      upd_valid = 1'b0;
      #1;
      if (lookup_ready === 1'b1 && pht_addr === 6'b010000) grants++;
      if (pred_valid !== 1'b1) pv_bad++;
    end
    checks++;
    if (grants != 8) begin
      errors++;
      $display("FAIL defer_grants: got %0d, expected 8", grants);
    end
    checks++;
    if (pv_bad != 0) begin
      errors++;
      $display("FAIL back_to_back_pred: %0d cycles without pred_valid, expected 0", pv_bad);
    end
    @(negedge clk);
    #1; checks++;
    if (!(lookup_ready === 1'b0 && pht_en === 1'b1 && pht_we === 1'b0 && pht_addr === 6'b100000)) begin
      errors++;
      $display("FAIL defer_upd_read: lrdy=%b en=%b we=%b addr=%b, expected 0 1 0 100000", lookup_ready, pht_en, pht_we, pht_addr);
    end
    @(negedge clk);
    #1; checks++;
    if (!(lookup_ready === 1'b0 && pht_en === 1'b0)) begin
      errors++;
      $display("FAIL defer_upd_rd: lrdy=%b en=%b, expected 0 0", lookup_ready, pht_en);
    end
    @(negedge clk);
    #1; checks++;
    if (!(lookup_ready === 1'b0 && pht_we === 1'b1 && pht_addr === 6'b100000 && pht_wdata === 2'b00)) begin
      errors++;
      $display("FAIL defer_upd_wr: lrdy=%b we=%b addr=%b wd=%b, expected 0 1 100000 00", lookup_ready, pht_we, pht_addr, pht_wdata);
    end
    @(negedge clk);
    #1; checks++;
    if (lookup_ready !== 1'b1) begin
      errors++;
      $display("FAIL defer_resume: lrdy=%b, expected 1", lookup_ready);
    end
  endtask

  task automatic test_fifo_full();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      lookup_valid = 1'b1; lookup_pc = 32'h10;
      upd_valid = 1'b1; upd_pc = 32'h0; upd_taken = 1'b1;
      #1; checks++;
      if (!(upd_ready === 1'b1 && lookup_ready === 1'b1)) begin
        errors++;
        $display("FAIL fill_c%0d: urdy=%b lrdy=%b, expected 1 1", c, upd_ready, lookup_ready);
      end
    end
    @(negedge clk);
    upd_valid = 1'b0;
    #1; checks++;
    if (!(upd_ready === 1'b0 && lookup_ready === 1'b0 && pht_en === 1'b1 && pht_we === 1'b0 && pht_addr === 6'b000000)) begin
      errors++;
      $display("FAIL full_win: urdy=%b lrdy=%b en=%b we=%b addr=%b, expected 0 0 1 0 000000",
               upd_ready, lookup_ready, pht_en, pht_we, pht_addr);
    end
    repeat (2) @(negedge clk);
    #1; checks++;
    if (!(pht_we === 1'b1 && pht_addr === 6'b000000 && pht_wdata === 2'b10)) begin
      errors++;
      $display("FAIL full_wr: we=%b addr=%b wd=%b, expected 1 000000 10", pht_we, pht_addr, pht_wdata);
    end
    @(negedge clk);
    lookup_valid = 1'b0;
    #1; checks++;
    if (!(pht_en === 1'b1 && pht_we === 1'b0 && pht_addr === 6'b000001)) begin
      errors++;
      $display("FAIL drain2_read: en=%b we=%b addr=%b, expected 1 0 000001", pht_en, pht_we, pht_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    #1; checks++;
    if (!(pht_we === 1'b1 && pht_addr === 6'b000001 && pht_wdata === 2'b10)) begin
      errors++;
      $display("FAIL midop_wr: we=%b addr=%b wd=%b, expected 1 000001 10", pht_we, pht_addr, pht_wdata);
    end
    rst_n = 1'b0;
    #1; checks++;
    if ({lookup_ready, pred_valid, pred_taken, upd_ready, pht_en, pht_we, pht_addr, pht_wdata, init_done} !== 15'd0) begin
      errors++;
      $display("FAIL midop_reset_outputs: en=%b we=%b addr=%h wd=%b urdy=%b done=%b, expected all 0",
               pht_en, pht_we, pht_addr, pht_wdata, upd_ready, init_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 64; k++) begin
      #1; checks++;
      if (!(pht_en === 1'b1 && pht_we === 1'b1 && pht_addr === 6'(k) && init_done === 1'b0)) begin
        errors++;
        $display("FAIL resweep[%0d]: en=%b we=%b addr=%0d done=%b, expected 1 1 %0d 0", k, pht_en, pht_we, pht_addr, init_done, k);
      end
      @(negedge clk);
    end
    for (int c = 0; c < 3; c++) begin
      #1; checks++;
      if (!(init_done === 1'b1 && upd_ready === 1'b1 && pht_en === 1'b0)) begin
        errors++;
        $display("FAIL fifo_flushed_c%0d: done=%b urdy=%b en=%b, expected 1 1 0", c, init_done, upd_ready, pht_en);
      end
      @(negedge clk);
    end
    lookup_valid = 1'b1; lookup_pc = 32'h0;
    #1; checks++;
    if (!(lookup_ready === 1'b1 && pht_addr === 6'b000000)) begin
      errors++;
      $display("FAIL bhr_cleared: rdy=%b addr=%b, expected 1 000000", lookup_ready, pht_addr);
    end
    lookup_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lookup();
    test_update_saturate();
    test_defer();
    test_fifo_full();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
